// File: rtl/alu_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer: Moore FSM driving ALU select, operand muxes and strobes,
// with a mem_ready stall handshake, a bounded memory-wait check and a sticky illegal flag.
module alu_ctrl_fsm #(
    parameter logic [3:0]  RESET_STATE  = 4'd0,
    parameter int unsigned MEM_WAIT_MAX = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        zero,
    input  logic        sign,
    input  logic        overflow,
    input  logic        cout,
    output logic [3:0]  aluc,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  imm_src,
    output logic [1:0]  result_src,
    output logic        adr_src,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic        mem_write,
    output logic        illegal
);

    // State codes are offsets from RESET_STATE so any reset encoding stays collision-free.
    localparam logic [3:0] StFetch    = RESET_STATE;
    localparam logic [3:0] StDecode   = RESET_STATE + 4'd1;
    localparam logic [3:0] StMemAdr   = RESET_STATE + 4'd2;
    localparam logic [3:0] StMemRead  = RESET_STATE + 4'd3;
    localparam logic [3:0] StMemWb    = RESET_STATE + 4'd4;
    localparam logic [3:0] StMemWrite = RESET_STATE + 4'd5;
    localparam logic [3:0] StExecR    = RESET_STATE + 4'd6;
    localparam logic [3:0] StExecI    = RESET_STATE + 4'd7;
    localparam logic [3:0] StAluWb    = RESET_STATE + 4'd8;
    localparam logic [3:0] StBranch   = RESET_STATE + 4'd9;
    localparam logic [3:0] StJal      = RESET_STATE + 4'd10;
    localparam logic [3:0] StJalrAdr  = RESET_STATE + 4'd11;
    localparam logic [3:0] StJalrJmp  = RESET_STATE + 4'd12;
    localparam logic [3:0] StLui      = RESET_STATE + 4'd13;
    localparam logic [3:0] StAuipc    = RESET_STATE + 4'd14;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpI      = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;

    localparam logic [3:0] AluAdd  = 4'b0000;
    localparam logic [3:0] AluSub  = 4'b0001;
    localparam logic [3:0] AluAnd  = 4'b0010;
    localparam logic [3:0] AluOr   = 4'b0011;
    localparam logic [3:0] AluSra  = 4'b0100;
    localparam logic [3:0] AluSlt  = 4'b0101;
    localparam logic [3:0] AluSrl  = 4'b0110;
    localparam logic [3:0] AluSll  = 4'b0111;
    localparam logic [3:0] AluSltu = 4'b1000;
    localparam logic [3:0] AluXor  = 4'b1001;

    localparam int unsigned    CntW    = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);
    localparam logic [CntW-1:0] WaitMax = CntW'(MEM_WAIT_MAX);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic            unused_instr;
    logic [3:0]      state_q, state_d, out_state;
    logic            illegal_q, illegal_d;
    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
    logic            waiting;
    logic            taken, br_bad;
    logic [3:0]      funct_aluc;

    assign opcode       = instr[6:0];
    assign funct3       = instr[14:12];
    assign funct7b5     = instr[30];
    assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};
    assign illegal      = illegal_q;

    assign waiting = ((state_q == StFetch) || (state_q == StMemRead) || (state_q == StMemWrite))
                     && !mem_ready;

    // Branch condition from ALU flags of rs1 - rs2.
    always_comb begin
        taken  = 1'b0;
        br_bad = 1'b0;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = sign ^ overflow;
            3'b101:  taken = !(sign ^ overflow);
            3'b110:  taken = !cout;
            3'b111:  taken = cout;
            default: br_bad = 1'b1;
        endcase
    end

    // ALU op for R/I-type execute; SUB only exists in R-type.
    always_comb begin
        funct_aluc = AluAdd;
        case (funct3)
            3'b000:  funct_aluc = (opcode == OpR && funct7b5) ? AluSub : AluAdd;
            3'b001:  funct_aluc = AluSll;
            3'b010:  funct_aluc = AluSlt;
            3'b011:  funct_aluc = AluSltu;
            3'b100:  funct_aluc = AluXor;
            3'b101:  funct_aluc = funct7b5 ? AluSra : AluSrl;
            3'b110:  funct_aluc = AluOr;
            default: funct_aluc = AluAnd;
        endcase
    end

    // Immediate format straight from the opcode, independent of state.
    always_comb begin
        case (opcode)
            OpStore:         imm_src = 3'b001;
            OpBranch:        imm_src = 3'b010;
            OpJal:           imm_src = 3'b011;
            OpLui, OpAuipc:  imm_src = 3'b100;
            default:         imm_src = 3'b000;
        endcase
    end

    // Next state, sticky illegal and memory-wait counter.
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        if (waiting) begin
            wait_cnt_d = (wait_cnt_q == WaitMax) ? wait_cnt_q : wait_cnt_q + CntW'(1);
        end else begin
            wait_cnt_d = '0;
        end
        // Timeout only flags; the FSM keeps waiting for mem_ready.
        if (MEM_WAIT_MAX != 0 && waiting && wait_cnt_q == WaitMax) begin
            illegal_d = 1'b1;
        end
        case (state_q)
            StFetch:    if (mem_ready) state_d = StDecode;
            StDecode: begin
                case (opcode)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpR:             state_d = StExecR;
                    OpI:             state_d = StExecI;
                    OpBranch:        state_d = StBranch;
                    OpJal:           state_d = StJal;
                    OpJalr:          state_d = StJalrAdr;
                    OpLui:           state_d = StLui;
                    OpAuipc:         state_d = StAuipc;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = StFetch;
                    end
                endcase
            end
            StMemAdr:   state_d = (opcode == OpLoad) ? StMemRead : StMemWrite;
            StMemRead:  if (mem_ready) state_d = StMemWb;
            StMemWb:    state_d = StFetch;
            StMemWrite: if (mem_ready) state_d = StFetch;
            StExecR:    state_d = StAluWb;
            StExecI:    state_d = StAluWb;
            StAluWb:    state_d = StFetch;
            StBranch: begin
                if (br_bad) illegal_d = 1'b1;
                state_d = StFetch;
            end
            StJal:      state_d = StAluWb;
            StJalrAdr:  state_d = StJalrJmp;
            StJalrJmp:  state_d = StAluWb;
            StLui:      state_d = StAluWb;
            StAuipc:    state_d = StAluWb;
            default:    state_d = StFetch;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StFetch;
            illegal_q  <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            illegal_q  <= illegal_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Moore outputs; reset presents FETCH values with every strobe held low.
    always_comb begin
        out_state  = reset ? StFetch : state_q;
        aluc       = AluAdd;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        case (out_state)
            StFetch: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            StDecode: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            StMemAdr, StJalrAdr: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            StMemRead:  adr_src = 1'b1;
            StMemWb: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            StMemWrite: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            StExecR: begin
                alu_src_a = 2'b10;
                aluc      = funct_aluc;
            end
            StExecI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                aluc      = funct_aluc;
            end
            StAluWb:    reg_write = 1'b1;
            StBranch: begin
                alu_src_a = 2'b10;
                aluc      = AluSub;
                pc_write  = taken;
            end
            StJal, StJalrJmp: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
            end
            StLui: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b01;
            end
            StAuipc: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            default: ;
        endcase
        if (reset) begin
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
            mem_write = 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Directed bench for alu_ctrl_fsm: walks instruction classes cycle by cycle and checks outputs.
module tb_alu_ctrl_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        mem_ready, zero, sign, overflow, cout;
    logic [3:0]  aluc;
    logic [1:0]  alu_src_a, alu_src_b, result_src;
    logic [2:0]  imm_src;
    logic        adr_src, ir_write, pc_write, reg_write, mem_write, illegal;

    int checks = 0;
    int passed = 0;

    alu_ctrl_fsm #(.RESET_STATE(4'd0), .MEM_WAIT_MAX(8)) dut (
        .clk(clk), .reset(reset), .instr(instr), .mem_ready(mem_ready), .zero(zero),
        .sign(sign), .overflow(overflow), .cout(cout), .aluc(aluc), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .imm_src(imm_src), .result_src(result_src), .adr_src(adr_src),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .mem_write(mem_write), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task step();
        @(posedge clk);
        #1;
    endtask

    task do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // From FETCH with mem_ready high, advance through FETCH and DECODE.
    task fetch_decode(input logic [31:0] ins);
        instr     = ins;
        mem_ready = 1'b1;
        step();
        step();
    endtask

    task test_reset();
        reset = 1'b1; instr = 32'h0; mem_ready = 1'b1;
        zero = 1'b0; sign = 1'b0; overflow = 1'b0; cout = 1'b0;
        #1;
        checks++;
        if ({ir_write, pc_write, reg_write, mem_write} !== 4'b0000)
            $display("FAIL reset_strobes: got %b want 0000",
                     {ir_write, pc_write, reg_write, mem_write});
        else passed++;
        checks++;
        if ({alu_src_a, alu_src_b, result_src, adr_src, aluc} !== 11'b00_10_10_0_0000)
            $display("FAIL reset_fetch_outs: got %b want 00101000000",
                     {alu_src_a, alu_src_b, result_src, adr_src, aluc});
        else passed++;
        step();
        checks++;
        if (illegal !== 1'b0) $display("FAIL reset_illegal: got %b want 0", illegal);
        else passed++;
        reset = 1'b0;
        #1;
        checks++;
        if ({ir_write, pc_write} !== 2'b11)
            $display("FAIL fetch_after_reset: got %b want 11", {ir_write, pc_write});
        else passed++;
    endtask

    task test_fetch_stall();
        mem_ready = 1'b0;
        #1;
        step();
        checks++;
        if ({ir_write, pc_write, alu_src_a, alu_src_b} !== 6'b00_00_10)
            $display("FAIL fetch_stall: got %b want 000010",
                     {ir_write, pc_write, alu_src_a, alu_src_b});
        else passed++;
        mem_ready = 1'b1;
        #1;
        checks++;
        if (ir_write !== 1'b1) $display("FAIL fetch_release: got %b want 1", ir_write);
        else passed++;
    endtask

    task test_add();
        int rw;
        rw = 0;
        instr = 32'h002081B3; mem_ready = 1'b1;
        #1;
        rw += int'(reg_write);
        step();
        checks++;
        if ({alu_src_a, alu_src_b} !== 4'b0101)
            $display("FAIL add_decode: got %b want 0101", {alu_src_a, alu_src_b});
        else passed++;
        rw += int'(reg_write);
        step();
        checks++;
        if ({alu_src_a, alu_src_b, aluc} !== 8'b10_00_0000)
            $display("FAIL add_execr: got %b want 10000000", {alu_src_a, alu_src_b, aluc});
        else passed++;
        rw += int'(reg_write);
        step();
        checks++;
        if ({result_src, reg_write} !== 3'b00_1)
            $display("FAIL add_aluwb: got %b want 001", {result_src, reg_write});
        else passed++;
        rw += int'(reg_write);
        step();
        rw += int'(reg_write);
        checks++;
        if (ir_write !== 1'b1) $display("FAIL add_back_to_fetch: got %b want 1", ir_write);
        else passed++;
        checks++;
        if (rw !== 1) $display("FAIL add_reg_write_count: got %0d want 1", rw);
        else passed++;
    endtask

    task test_alu_decode();
        logic [31:0] ins  [0:10];
        logic [5:0]  expv [0:10];  // {alu_src_b, aluc}
        ins  = '{32'h402081B3, 32'h4020D1B3, 32'h0020D1B3, 32'h0020B1B3, 32'h002091B3,
                 32'h4030D093, 32'h40008093, 32'h0040C093, 32'h0040A093, 32'h0040E093,
                 32'h0040F093};
        expv = '{6'b00_0001, 6'b00_0100, 6'b00_0110, 6'b00_1000, 6'b00_0111,
                 6'b01_0100, 6'b01_0000, 6'b01_1001, 6'b01_0101, 6'b01_0011,
                 6'b01_0010};
        for (int i = 0; i < 11; i++) begin
            fetch_decode(ins[i]);
            checks++;
            if ({alu_src_a, alu_src_b, aluc} !== {2'b10, expv[i]})
                $display("FAIL alu_decode[%0d] %h: got %b want %b", i, ins[i],
                         {alu_src_a, alu_src_b, aluc}, {2'b10, expv[i]});
            else passed++;
            step();
            step();
        end
    endtask

    task test_branch();
        logic [2:0] f3  [0:9];
        logic [3:0] flg [0:9];  // {zero, sign, overflow, cout}
        logic       tk  [0:9];
        f3  = '{3'b100, 3'b111, 3'b001, 3'b000, 3'b001, 3'b101, 3'b101, 3'b110, 3'b110, 3'b111};
        flg = '{4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0110, 4'b0100, 4'b0000,
                4'b0001, 4'b0001};
        tk  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 10; i++) begin
            {zero, sign, overflow, cout} = flg[i];
            instr = {17'd0, f3[i], 5'd0, 7'b1100011};
            mem_ready = 1'b1;
            step();
            checks++;
            if (imm_src !== 3'b010) $display("FAIL branch_imm[%0d]: got %b want 010", i, imm_src);
            else passed++;
            step();
            checks++;
            if ({pc_write, alu_src_a, alu_src_b, aluc} !== {tk[i], 8'b10_00_0001})
                $display("FAIL branch[%0d] f3=%b: got %b want %b", i, f3[i],
                         {pc_write, alu_src_a, alu_src_b, aluc}, {tk[i], 8'b10_00_0001});
            else passed++;
            step();
        end
        checks++;
        if (illegal !== 1'b0) $display("FAIL branch_no_illegal: got %b want 0", illegal);
        else passed++;
        fetch_decode({17'd0, 3'b010, 5'd0, 7'b1100011});
        checks++;
        if (pc_write !== 1'b0) $display("FAIL branch_f3_010_taken: got %b want 0", pc_write);
        else passed++;
        step();
        checks++;
        if (illegal !== 1'b1) $display("FAIL branch_f3_010_illegal: got %b want 1", illegal);
        else passed++;
        do_reset();
    endtask

    task test_load();
        fetch_decode(32'h0000A183);
        checks++;
        if ({alu_src_a, alu_src_b, aluc} !== 8'b10_01_0000)
            $display("FAIL lw_memadr: got %b want 10010000", {alu_src_a, alu_src_b, aluc});
        else passed++;
        mem_ready = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({adr_src, result_src, reg_write, ir_write} !== 5'b1_00_0_0)
                $display("FAIL lw_memread_wait[%0d]: got %b want 10000", i,
                         {adr_src, result_src, reg_write, ir_write});
            else passed++;
            step();
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if (adr_src !== 1'b1) $display("FAIL lw_memread_4th: got %b want 1", adr_src);
        else passed++;
        step();
        checks++;
        if ({result_src, reg_write} !== 3'b01_1)
            $display("FAIL lw_memwb: got %b want 011", {result_src, reg_write});
        else passed++;
        step();
        checks++;
        if ({ir_write, reg_write} !== 2'b10)
            $display("FAIL lw_back_to_fetch: got %b want 10", {ir_write, reg_write});
        else passed++;
    endtask

    // Leaves the FSM in MEMWRITE with mem_ready low.
    task enter_store();
        instr = 32'h0030A023; mem_ready = 1'b1;
        step();
        checks++;
        if (imm_src !== 3'b001) $display("FAIL sw_imm: got %b want 001", imm_src);
        else passed++;
        step();
        mem_ready = 1'b0;
        step();
    endtask

    task test_store();
        enter_store();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({mem_write, adr_src, result_src, ir_write} !== 5'b1_1_00_0)
                $display("FAIL sw_wait[%0d]: got %b want 11000", i,
                         {mem_write, adr_src, result_src, ir_write});
            else passed++;
            step();
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if (mem_write !== 1'b1) $display("FAIL sw_ready: got %b want 1", mem_write);
        else passed++;
        step();
        checks++;
        if ({mem_write, ir_write, illegal} !== 3'b010)
            $display("FAIL sw_done: got %b want 010", {mem_write, ir_write, illegal});
        else passed++;
    endtask

    task test_timeout();
        enter_store();
        repeat (7) step();
        checks++;
        if ({illegal, mem_write} !== 2'b01)
            $display("FAIL timeout_early: got %b want 01", {illegal, mem_write});
        else passed++;
        repeat (2) step();
        checks++;
        if ({illegal, mem_write} !== 2'b11)
            $display("FAIL timeout_flag: got %b want 11", {illegal, mem_write});
        else passed++;
        mem_ready = 1'b1;
        step();
        checks++;
        if ({illegal, ir_write, mem_write} !== 3'b110)
            $display("FAIL timeout_sticky: got %b want 110", {illegal, ir_write, mem_write});
        else passed++;
        do_reset();
    endtask

    task test_jump();
        instr = 32'h0000006F; mem_ready = 1'b1;
        step();
        checks++;
        if (imm_src !== 3'b011) $display("FAIL jal_imm: got %b want 011", imm_src);
        else passed++;
        step();
        checks++;
        if ({alu_src_a, alu_src_b, result_src, pc_write, aluc} !== 11'b01_10_00_1_0000)
            $display("FAIL jal: got %b want 01100010000",
                     {alu_src_a, alu_src_b, result_src, pc_write, aluc});
        else passed++;
        step();
        checks++;
        if (reg_write !== 1'b1) $display("FAIL jal_wb: got %b want 1", reg_write);
        else passed++;
        step();
        fetch_decode(32'h000080E7);
        checks++;
        if ({alu_src_a, alu_src_b, pc_write} !== 5'b10_01_0)
            $display("FAIL jalr_adr: got %b want 10010", {alu_src_a, alu_src_b, pc_write});
        else passed++;
        step();
        checks++;
        if ({alu_src_a, alu_src_b, result_src, pc_write} !== 7'b01_10_00_1)
            $display("FAIL jalr_jmp: got %b want 0110001",
                     {alu_src_a, alu_src_b, result_src, pc_write});
        else passed++;
        step();
        step();
        instr = 32'h000011B7;
        step();
        checks++;
        if (imm_src !== 3'b100) $display("FAIL lui_imm: got %b want 100", imm_src);
        else passed++;
        step();
        checks++;
        if ({alu_src_a, alu_src_b, reg_write} !== 5'b11_01_0)
            $display("FAIL lui: got %b want 11010", {alu_src_a, alu_src_b, reg_write});
        else passed++;
        step();
        step();
        fetch_decode(32'h00001197);
        checks++;
        if ({alu_src_a, alu_src_b, aluc} !== 8'b01_01_0000)
            $display("FAIL auipc: got %b want 01010000", {alu_src_a, alu_src_b, aluc});
        else passed++;
        step();
        step();
    endtask

    task test_bad_opcode();
        instr = 32'h0000007F; mem_ready = 1'b1;
        step();
        checks++;
        if (illegal !== 1'b0) $display("FAIL badop_decode: got %b want 0", illegal);
        else passed++;
        step();
        checks++;
        if ({illegal, ir_write} !== 2'b11)
            $display("FAIL badop_illegal: got %b want 11", {illegal, ir_write});
        else passed++;
    endtask

    // Starts with illegal set from the previous test; reset must clear it.
    task test_reset_mid();
        fetch_decode(32'h002081B3);
        reset = 1'b1;
        #1;
        checks++;
        if ({ir_write, pc_write, reg_write, mem_write} !== 4'b0000)
            $display("FAIL rst_mid_strobes: got %b want 0000",
                     {ir_write, pc_write, reg_write, mem_write});
        else passed++;
        step();
        reset = 1'b0;
        #1;
        checks++;
        if ({ir_write, alu_src_a, alu_src_b, reg_write, illegal} !== 7'b1_00_10_0_0)
            $display("FAIL rst_mid_fetch: got %b want 1001000",
                     {ir_write, alu_src_a, alu_src_b, reg_write, illegal});
        else passed++;
        step();
        checks++;
        if ({alu_src_a, alu_src_b, reg_write} !== 5'b01_01_0)
            $display("FAIL rst_mid_decode: got %b want 01010", {alu_src_a, alu_src_b, reg_write});
        else passed++;
    endtask

    initial begin
        test_reset();
        test_fetch_stall();
        test_add();
        test_alu_decode();
        test_branch();
        test_load();
        test_store();
        test_timeout();
        test_jump();
        test_bad_opcode();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
